// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RISC-V datapath: fetch/decode/execute/memory/writeback.
// Define CTRL_ILLEGAL_TRAP_EN to make illegal opcodes lock into TRAP; otherwise they retire as NOPs.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       selectedFlag,
    input  logic       mem_ready,
    output logic       pc_load,
    output logic       pc_src,
    output logic       ir_load,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_req,
    output logic       mem_we,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    // ILLEGAL is the cleared value so a fresh reset never looks like a real instruction.
    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_R       = 3'd1,
        C_I       = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_BRANCH  = 3'd5
    } class_t;

    state_t state_q, state_d;
    class_t class_q, class_d;
    class_t dec_class;

    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            default:    dec_class = C_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == C_ILLEGAL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_WRITEBACK;
`endif
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (class_q)
                    C_R, C_I:         state_d = S_WRITEBACK;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == C_LOAD) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            class_q <= C_ILLEGAL;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Outputs are decoded from the current state and forced low while reset is high,
    // so an in-flight memory request is withdrawn in the same cycle reset arrives.
    always_comb begin
        pc_load       = 1'b0;
        pc_src        = 1'b0;
        ir_load       = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        illegal_instr = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: ir_load = 1'b1;
                S_EXECUTE: begin
                    case (class_q)
                        C_R: begin
                            alu_op  = 2'b10;
                            alu_src = 1'b0;
                        end
                        C_I: begin
                            alu_op  = 2'b11;
                            alu_src = 1'b1;
                        end
                        C_LOAD, C_STORE: begin
                            alu_op  = 2'b00;
                            alu_src = 1'b1;
                        end
                        C_BRANCH: begin
                            alu_op  = 2'b01;
                            alu_src = 1'b0;
                            pc_load = 1'b1;
                            pc_src  = selectedFlag;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == C_STORE);
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                    // A store retires in the cycle its memory access completes.
                    if (mem_ready && class_q == C_STORE) begin
                        pc_load = 1'b1;
                        pc_src  = 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = (class_q != C_ILLEGAL);
                    mem_to_reg = (class_q == C_LOAD);
                    pc_load    = 1'b1;
                    pc_src     = 1'b0;
                    if (class_q == C_R) begin
                        alu_op  = 2'b10;
                        alu_src = 1'b0;
                    end else if (class_q == C_I) begin
                        alu_op  = 2'b11;
                        alu_src = 1'b1;
                    end
                end
                S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_instr = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign instr_retired = pc_load;
    assign state         = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected output vectors through a queue.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       selectedFlag;
  logic       mem_ready;
  logic       pc_load, pc_src, ir_load, alu_src;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, mem_req, mem_we, instr_retired, illegal_instr;
  logic [2:0] state;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .selectedFlag(selectedFlag),
    .mem_ready(mem_ready), .pc_load(pc_load), .pc_src(pc_src), .ir_load(ir_load),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .mem_req(mem_req), .mem_we(mem_we), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr), .state(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, pc_load, pc_src, ir_load, alu_src, alu_op, reg_write, mem_to_reg, mem_req, mem_we, instr_retired, illegal_instr}
  function automatic logic [14:0] mk(input logic [2:0] st, input logic pcl, input logic pcs,
                                     input logic irl, input logic als, input logic [1:0] alop,
                                     input logic rw, input logic m2r, input logic mrq,
                                     input logic mwe, input logic ill);
    return {st, pcl, pcs, irl, als, alop, rw, m2r, mrq, mwe, pcl, ill};
  endfunction

  function automatic logic [14:0] observed();
    return {state, pc_load, pc_src, ir_load, alu_src, alu_op, reg_write, mem_to_reg,
            mem_req, mem_we, instr_retired, illegal_instr};
  endfunction

  // driver: apply inputs after the falling edge, queue the expectation, check before the rising edge
  task automatic cyc(input logic rst, input logic [6:0] op, input logic flag, input logic rdy,
                     input logic [14:0] exp_v, input string tag);
    logic [14:0] e;
    logic [14:0] o;
    reset = rst;
    opcode = op;
    selectedFlag = flag;
    mem_ready = rdy;
    exp_q.push_back(exp_v);
    #2;
    o = observed();
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, o, e);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  logic [14:0] v_f, v_d, v_0;

  // stimulus
  initial begin
    reset = 1'b1;
    opcode = 7'd0;
    selectedFlag = 1'b0;
    mem_ready = 1'b0;
    v_f = mk(3'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    v_d = mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    v_0 = 15'd0;
    @(negedge clk);

    // reset held three cycles with noisy inputs
    for (int i = 0; i < 3; i++) cyc(1, OP_B, 1, 1, v_0, "reset_hold");

    // R-type; opcode changes after decode to prove the class is registered
    cyc(0, OP_R, rb(), rb(), v_f, "r_fetch");
    cyc(0, OP_R, rb(), rb(), v_d, "r_decode");
    cyc(0, OP_B, rb(), rb(), mk(3'd2, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0), "r_exec");
    cyc(0, OP_L, rb(), rb(), mk(3'd4, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0), "r_wb");

    // I-ALU
    cyc(0, OP_I, rb(), rb(), v_f, "i_fetch");
    cyc(0, OP_I, rb(), rb(), v_d, "i_decode");
    cyc(0, OP_I, rb(), rb(), mk(3'd2, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0), "i_exec");
    cyc(0, OP_S, rb(), rb(), mk(3'd4, 1, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0), "i_wb");

    // BRANCH taken then not taken
    cyc(0, OP_B, 0, rb(), v_f, "bt_fetch");
    cyc(0, OP_B, 0, rb(), v_d, "bt_decode");
    cyc(0, OP_B, 1, rb(), mk(3'd2, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0), "bt_exec");
    cyc(0, OP_B, 1, rb(), v_f, "bn_fetch");
    cyc(0, OP_B, 1, rb(), v_d, "bn_decode");
    cyc(0, OP_B, 0, rb(), mk(3'd2, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0), "bn_exec");

    // LOAD with two wait states; mem_ready high outside MEM is ignored
    cyc(0, OP_L, rb(), 1, v_f, "ld_fetch");
    cyc(0, OP_L, rb(), 1, v_d, "ld_decode");
    cyc(0, OP_L, rb(), 1, mk(3'd2, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0), "ld_exec");
    cyc(0, OP_L, rb(), 0, mk(3'd3, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0), "ld_mem_wait1");
    cyc(0, OP_L, rb(), 0, mk(3'd3, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0), "ld_mem_wait2");
    cyc(0, OP_L, rb(), 1, mk(3'd3, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0), "ld_mem_done");
    cyc(0, OP_S, rb(), 1, mk(3'd4, 1, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0), "ld_wb");

    // STORE with ready already high on MEM entry (retires from MEM)
    cyc(0, OP_S, rb(), 0, v_f, "st_fetch");
    cyc(0, OP_S, rb(), 0, v_d, "st_decode");
    cyc(0, OP_S, rb(), 1, mk(3'd2, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0), "st_exec");
    cyc(0, OP_L, rb(), 1, mk(3'd3, 1, 0, 0, 1, 2'b00, 0, 0, 1, 1, 0), "st_mem_done");

    // STORE abandoned by reset in its second MEM cycle
    cyc(0, OP_S, rb(), 0, v_f, "sr_fetch");
    cyc(0, OP_S, rb(), 0, v_d, "sr_decode");
    cyc(0, OP_S, rb(), 0, mk(3'd2, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0), "sr_exec");
    cyc(0, OP_S, rb(), 0, mk(3'd3, 0, 0, 0, 1, 2'b00, 0, 0, 1, 1, 0), "sr_mem1");
    cyc(1, OP_S, rb(), 1, v_0, "sr_mem2_reset");
    cyc(0, OP_R, rb(), 0, v_f, "sr_after_reset");
    cyc(0, OP_R, rb(), 0, v_d, "sr_next_decode");
    cyc(0, OP_R, rb(), 0, mk(3'd2, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0), "sr_next_exec");
    cyc(0, OP_R, rb(), 0, mk(3'd4, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0), "sr_next_wb");

    // illegal opcode
    cyc(0, OP_BAD, rb(), rb(), v_f, "il_fetch");
    cyc(0, OP_BAD, rb(), rb(), v_d, "il_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      cyc(0, (i % 2 == 0) ? OP_R : OP_BAD, rb(), rb(),
          mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1), "il_trap_hold");
    cyc(1, OP_R, rb(), rb(), v_0, "il_trap_reset");
`else
    cyc(0, OP_R, rb(), rb(), mk(3'd4, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), "il_nop_wb");
`endif
    cyc(0, OP_I, rb(), rb(), v_f, "final_fetch");
    cyc(0, OP_I, rb(), rb(), v_d, "final_decode");

    // final report
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, 0 expected", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
